// File: rtl/mbe_arb_pkg.sv
// Shared widths, types and the round-robin pick helper for the MBE multiplier arbiter.
package mbe_arb_pkg;

  localparam int DWIDTH = 11;
  localparam int NREQ   = 4;
  localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PWIDTH = 2 * DWIDTH;

  typedef struct packed {
    logic [PWIDTH-1:0] data;
    logic [ID_W-1:0]   id;
  } res_entry_t;

  typedef struct packed {
    logic            found;
    logic [ID_W-1:0] idx;
  } pick_t;

  // Scanning from the far end lets the lowest offset from ptr overwrite the rest.
  function automatic pick_t rr_pick(input logic [NREQ-1:0] valid, input logic [ID_W-1:0] ptr);
    pick_t           pick;
    logic [ID_W-1:0] idx;
    pick = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = ID_W'((int'(ptr) + i) % NREQ);
      if (valid[idx]) begin
        pick.found = 1'b1;
        pick.idx   = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mbe_res_fifo.sv
// Synchronous show-ahead FIFO holding id-tagged multiplier products.
module mbe_res_fifo
  import mbe_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  res_entry_t push_data_i,
  input  logic       pop_i,
  output res_entry_t head_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  res_entry_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o    = (r_count == CW'(DEPTH));
  assign empty_o   = (r_count == '0);
  assign w_do_push = push_i & ~full_o;
  assign w_do_pop  = pop_i & ~empty_o;
  assign head_o    = r_mem[r_rd_ptr];

  // NOTE: storage is not reset; r_count alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= wrap_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= wrap_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mbe_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined MBE multiplier among NREQ requesters,
// with id tags carried through the multiplier and credit-protected result buffering.
module mbe_mul_arbiter
  import mbe_arb_pkg::*;
#(
  parameter int MUL_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NREQ-1:0]        req_valid_i,
  output logic [NREQ-1:0]        req_ready_o,
  input  logic [NREQ*DWIDTH-1:0] req_a_i,
  input  logic [NREQ*DWIDTH-1:0] req_b_i,
  output logic [DWIDTH-1:0]      mul_a_o,
  output logic [DWIDTH-1:0]      mul_b_o,
  output logic                   mul_valid_o,
  input  logic [PWIDTH-1:0]      mul_result_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [PWIDTH-1:0]      res_data_o,
  output logic [ID_W-1:0]        res_id_o,
  output logic                   busy_o
);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  if (MUL_LAT < 1 || FIFO_DEPTH < 1) begin : g_bad_param
    $error("mbe_mul_arbiter: MUL_LAT and FIFO_DEPTH must be >= 1");
  end

  logic [ID_W-1:0]  r_rr_ptr;
  logic [OCC_W-1:0] r_occ;
  logic             r_tag_vld [MUL_LAT];
  logic [ID_W-1:0]  r_tag_id  [MUL_LAT];
  pick_t            w_pick;
  logic             w_can_issue;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  res_entry_t       w_push_entry;
  res_entry_t       w_head;

  // Credit counts everything issued but not yet popped, so the FIFO can never overflow.
  assign w_pick      = rr_pick(req_valid_i, r_rr_ptr);
  assign w_can_issue = (r_occ < OCC_W'(FIFO_DEPTH));
  assign w_issue     = w_pick.found & w_can_issue;
  assign mul_valid_o = w_issue;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    req_ready_o = '0;
    mul_a_o     = '0;
    mul_b_o     = '0;
    if (w_issue) begin
      req_ready_o[w_pick.idx] = 1'b1;
      mul_a_o = req_a_i[w_pick.idx * DWIDTH +: DWIDTH];
      mul_b_o = req_b_i[w_pick.idx * DWIDTH +: DWIDTH];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so each flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_issue) r_rr_ptr <= (w_pick.idx == ID_W'(NREQ - 1)) ? '0 : w_pick.idx + 1'b1;
      case ({w_issue, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: ;
      endcase
    end
  end

  // Only the valid bits need reset; stale multiplier outputs are then never captured.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < MUL_LAT; s++) r_tag_vld[s] <= 1'b0;
    end else begin
      r_tag_vld[0] <= w_issue;
      for (int s = 1; s < MUL_LAT; s++) r_tag_vld[s] <= r_tag_vld[s-1];
    end
  end

  always_ff @(posedge clk_i) begin
    r_tag_id[0] <= w_pick.idx;
    for (int s = 1; s < MUL_LAT; s++) r_tag_id[s] <= r_tag_id[s-1];
  end

  assign w_push       = r_tag_vld[MUL_LAT-1];
  assign w_push_entry = '{data: mul_result_i, id: r_tag_id[MUL_LAT-1]};
  assign w_pop        = res_valid_o & res_ready_i;

  mbe_res_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_push),
    .push_data_i (w_push_entry),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty)
  );

  assign res_valid_o = ~w_empty;
  assign res_data_o  = w_empty ? '0 : w_head.data;
  assign res_id_o    = w_empty ? '0 : w_head.id;
  assign busy_o      = (r_occ != '0);

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(w_push && w_full))
    else $error("mbe_mul_arbiter: result FIFO push while full");

endmodule

// File: tb/tb_mbe_mul_arbiter.sv
// Directed self-checking bench for mbe_mul_arbiter with a signed two-stage multiplier model.
module tb_mbe_mul_arbiter;
  import mbe_arb_pkg::*;

  localparam int MUL_LAT    = 2;
  localparam int FIFO_DEPTH = 4;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic [NREQ-1:0]        req_valid_i;
  logic [NREQ-1:0]        req_ready_o;
  logic [NREQ*DWIDTH-1:0] req_a_i;
  logic [NREQ*DWIDTH-1:0] req_b_i;
  logic [DWIDTH-1:0]      mul_a_o;
  logic [DWIDTH-1:0]      mul_b_o;
  logic                   mul_valid_o;
  logic [PWIDTH-1:0]      mul_result_i;
  logic                   res_valid_o;
  logic                   res_ready_i;
  logic [PWIDTH-1:0]      res_data_o;
  logic [ID_W-1:0]        res_id_o;
  logic                   busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  mbe_mul_arbiter #(
    .MUL_LAT    (MUL_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .mul_a_o      (mul_a_o),
    .mul_b_o      (mul_b_o),
    .mul_valid_o  (mul_valid_o),
    .mul_result_i (mul_result_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_data_o   (res_data_o),
    .res_id_o     (res_id_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Signed multiplier with MUL_LAT register stages between operands and product.
  logic signed [PWIDTH-1:0] w_prod;
  logic [PWIDTH-1:0]        r_mul [MUL_LAT];
  assign w_prod = $signed(mul_a_o) * $signed(mul_b_o);
  always_ff @(posedge clk_i) begin
    r_mul[0] <= w_prod;
    for (int s = 1; s < MUL_LAT; s++) r_mul[s] <= r_mul[s-1];
  end
  assign mul_result_i = r_mul[MUL_LAT-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_op(input int k, input logic [DWIDTH-1:0] a, input logic [DWIDTH-1:0] b);
    req_a_i[k*DWIDTH +: DWIDTH] = a;
    req_b_i[k*DWIDTH +: DWIDTH] = b;
  endtask

  // Leaves the bench one cycle after reset was sampled, with rst_i already released.
  task automatic do_reset();
    rst_i       = 1'b1;
    req_valid_i = '0;
    cyc();
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_prod [NREQ];
    int exp_grant [4];
    int exp_a [4];
    exp_prod  = '{10, 40, 90, 160};
    exp_grant = '{4, 1, 4, 1};
    exp_a     = '{7, 5, 7, 5};

    rst_i       = 1'b1;
    req_valid_i = '0;
    req_a_i     = '0;
    req_b_i     = '0;
    res_ready_i = 1'b0;
    cyc();
    do_reset();
    settle();
    check("rst res_valid", res_valid_o, 0);
    check("rst busy", busy_o, 0);
    check("rst req_ready", req_ready_o, 0);
    check("rst mul_valid", mul_valid_o, 0);
    check("rst mul_a", mul_a_o, 0);
    check("rst res_data", res_data_o, 0);
    check("rst res_id", res_id_o, 0);

    // 1: single product, latency and busy fall
    res_ready_i = 1'b1;
    set_op(0, 11'd3, 11'd5);
    req_valid_i = 4'b0001;
    settle();
    check("t1 ready", req_ready_o, 4'b0001);
    check("t1 mul_valid", mul_valid_o, 1);
    check("t1 mul_a", mul_a_o, 3);
    check("t1 mul_b", mul_b_o, 5);
    cyc();
    req_valid_i = '0;
    settle();
    check("t1 c1 res_valid", res_valid_o, 0);
    check("t1 c1 busy", busy_o, 1);
    cyc();
    check("t1 c2 res_valid", res_valid_o, 0);
    cyc();
    check("t1 c3 res_valid", res_valid_o, 1);
    check("t1 c3 data", res_data_o, 15);
    check("t1 c3 id", res_id_o, 0);
    check("t1 c3 busy", busy_o, 1);
    cyc();
    check("t1 c4 busy", busy_o, 0);
    check("t1 c4 res_valid", res_valid_o, 0);

    // 2: negative operand
    set_op(0, 11'h7FF, 11'd2);
    req_valid_i = 4'b0001;
    settle();
    check("t2 ready", req_ready_o, 4'b0001);
    cyc();
    req_valid_i = '0;
    cyc();
    cyc();
    check("t2 res_valid", res_valid_o, 1);
    check("t2 data", res_data_o, 22'h3FFFFE);
    check("t2 id", res_id_o, 0);
    cyc();

    // 3: all requesters valid, full throughput
    do_reset();
    for (int k = 0; k < NREQ; k++) set_op(k, DWIDTH'(k + 1), DWIDTH'(10 * (k + 1)));
    res_ready_i = 1'b1;
    for (int c = 0; c < 11; c++) begin
      req_valid_i = (c < 8) ? '1 : '0;
      settle();
      if (c < 8) check($sformatf("t3 grant c%0d", c), req_ready_o, 1 << (c % 4));
      if (c >= 3) begin
        check($sformatf("t3 res_valid c%0d", c), res_valid_o, 1);
        check($sformatf("t3 id c%0d", c), res_id_o, (c - 3) % 4);
        check($sformatf("t3 data c%0d", c), res_data_o, exp_prod[(c - 3) % 4]);
      end else begin
        check($sformatf("t3 res_valid c%0d", c), res_valid_o, 0);
      end
      cyc();
    end

    // 4: backpressure, credit exhaustion, single pop
    res_ready_i = 1'b0;
    for (int c = 0; c < 7; c++) begin
      req_valid_i = '1;
      settle();
      check($sformatf("t4 grant c%0d", c), req_ready_o, (c < 4) ? (1 << c) : 0);
      cyc();
    end
    check("t4 full res_valid", res_valid_o, 1);
    check("t4 full head id", res_id_o, 0);
    check("t4 full head data", res_data_o, 10);
    res_ready_i = 1'b1;
    settle();
    check("t4 pop cycle ready", req_ready_o, 0);
    cyc();
    res_ready_i = 1'b0;
    settle();
    check("t4 after pop ready", req_ready_o, 4'b0001);
    check("t4 after pop head id", res_id_o, 1);
    check("t4 after pop head data", res_data_o, 40);
    cyc();
    check("t4 refill ready", req_ready_o, 0);
    req_valid_i = '0;
    res_ready_i = 1'b1;
    repeat (8) cyc();
    check("t4 drained busy", busy_o, 0);

    // 5: rr_ptr=1, req0 and req2 alternate starting at 2
    do_reset();
    set_op(0, 11'd5, 11'd1);
    set_op(2, 11'd7, 11'd1);
    req_valid_i = 4'b0001;
    settle();
    check("t5 setup ready", req_ready_o, 4'b0001);
    cyc();
    req_valid_i = '0;
    repeat (4) cyc();
    for (int c = 0; c < 4; c++) begin
      req_valid_i = 4'b0101;
      settle();
      check($sformatf("t5 grant c%0d", c), req_ready_o, exp_grant[c]);
      check($sformatf("t5 mul_a c%0d", c), mul_a_o, exp_a[c]);
      cyc();
    end
    req_valid_i = '0;
    repeat (5) cyc();

    // 6: reset with two products in flight
    req_valid_i = 4'b0011;
    settle();
    check("t6 issue0", mul_valid_o, 1);
    cyc();
    check("t6 issue1", mul_valid_o, 1);
    cyc();
    req_valid_i = '0;
    rst_i       = 1'b1;
    settle();
    check("t6 busy before rst", busy_o, 1);
    cyc();
    rst_i = 1'b0;
    for (int c = 0; c < MUL_LAT + 3; c++) begin
      check($sformatf("t6 res_valid c%0d", c), res_valid_o, 0);
      check($sformatf("t6 busy c%0d", c), busy_o, 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
